// File: rtl/vga_capture.sv
// VGA capture front end: checks incoming video timing against the expected active
// window and, once timing is verified, writes a 2x-decimated copy into a framebuffer.
module vga_capture #(
  parameter int H_ACT       = 560,
  parameter int V_ACT       = 384,
  parameter int FB_WORDS    = 53760,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        clock_50,
  input  logic        reset,
  input  logic        pix_en,
  input  logic        vga_hs,
  input  logic        vga_vs,
  input  logic        vga_blank_n,
  input  logic [7:0]  vga_r,
  input  logic [7:0]  vga_g,
  input  logic [7:0]  vga_b,
  output logic [15:0] wr_adr,
  output logic [23:0] wr_data,
  output logic        wr_en,
  output logic        locked,
  output logic        frame_done,
  output logic        err
);

  localparam logic [9:0]  H_ACT_W    = 10'(H_ACT);
  localparam logic [9:0]  V_ACT_W    = 10'(V_ACT);
  localparam logic [16:0] FB_WORDS_W = 17'(FB_WORDS);
  localparam logic [7:0]  LOCK_W     = 8'(LOCK_FRAMES);
  localparam logic [9:0]  CNT_MAX    = 10'h3FF;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    ALIGN   = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic        r_hs_prev;
  logic        r_vs_prev;
  logic [9:0]  r_pix_cnt;
  logic [9:0]  r_line_cnt;
  logic        r_bad;
  logic [16:0] r_ptr;
  logic [7:0]  r_good_cnt;
  logic [7:0]  w_good_cnt_next;
  logic        w_locked_next;
  logic        w_frame_done_next;
  logic        w_err_set;
  logic        w_hs_fall;
  logic        w_vs_fall;
  logic        w_active;
  logic [9:0]  w_pix_now;
  logic        w_line_end;
  logic        w_line_has;
  logic        w_line_bad;
  logic [9:0]  w_lines_now;
  logic        w_frame_good;
  logic        w_wr_ok;
  logic [15:0] r_wr_adr;
  logic [23:0] r_wr_data;
  logic        r_wr_en;
  logic        r_locked;
  logic        r_frame_done;
  logic        r_err;

  assign w_hs_fall = pix_en & r_hs_prev & ~vga_hs;
  assign w_vs_fall = pix_en & r_vs_prev & ~vga_vs;
  assign w_active  = pix_en & vga_blank_n;
  assign w_pix_now = (w_active && (r_pix_cnt != CNT_MAX)) ? r_pix_cnt + 10'd1 : r_pix_cnt;

  // A vsync edge also closes the line in progress, so a line ending on a
  // coincident hsync/vsync sample is still judged as part of the old frame.
  assign w_line_end   = w_hs_fall | w_vs_fall;
  assign w_line_has   = w_line_end & (w_pix_now != 10'd0);
  assign w_line_bad   = w_line_has & (w_pix_now != H_ACT_W);
  assign w_lines_now  = (w_line_has && (r_line_cnt != CNT_MAX)) ? r_line_cnt + 10'd1 : r_line_cnt;
  assign w_frame_good = ~r_bad & ~w_line_bad & (w_lines_now == V_ACT_W) & (w_lines_now != CNT_MAX);

  assign w_wr_ok = (r_state == CAPTURE) & w_active & ~w_vs_fall & ~r_bad
                 & ~r_pix_cnt[0] & ~r_line_cnt[0]
                 & (r_pix_cnt < H_ACT_W) & (r_ptr < FB_WORDS_W);

  always_ff @(posedge clock_50 or negedge reset) begin
    if (!reset) begin
      r_hs_prev <= 1'b0;
      r_vs_prev <= 1'b0;
    end else if (pix_en) begin
      r_hs_prev <= vga_hs;
      r_vs_prev <= vga_vs;
    end
  end

  always_ff @(posedge clock_50 or negedge reset) begin
    if (!reset) begin
      r_pix_cnt  <= 10'd0;
      r_line_cnt <= 10'd0;
      r_bad      <= 1'b0;
      r_ptr      <= 17'd0;
    end else if (w_vs_fall) begin
      r_pix_cnt  <= 10'd0;
      r_line_cnt <= 10'd0;
      r_bad      <= 1'b0;
      r_ptr      <= 17'd0;
    end else begin
      if (w_hs_fall) begin
        r_pix_cnt  <= 10'd0;
        r_line_cnt <= w_lines_now;
        if (w_line_bad || (w_lines_now == CNT_MAX)) begin
          r_bad <= 1'b1;
        end
      end else begin
        r_pix_cnt <= w_pix_now;
      end
      if (w_wr_ok) begin
        r_ptr <= r_ptr + 17'd1;
      end
    end
  end

  always_ff @(posedge clock_50 or negedge reset) begin
    if (!reset) begin
      r_state    <= SEARCH;
      r_good_cnt <= 8'd0;
    end else begin
      r_state    <= w_state_next;
      r_good_cnt <= w_good_cnt_next;
    end
  end

  // All state decisions happen only on a vsync falling edge, using the
  // verdict on the frame that edge closes.
  always_comb begin
    w_state_next      = r_state;
    w_good_cnt_next   = r_good_cnt;
    w_locked_next     = r_locked;
    w_frame_done_next = 1'b0;
    w_err_set         = 1'b0;
    if (w_vs_fall) begin
      case (r_state)
        SEARCH: begin
          w_state_next    = ALIGN;
          w_good_cnt_next = 8'd0;
        end
        ALIGN: begin
          if (w_frame_good) begin
            if ((r_good_cnt + 8'd1) >= LOCK_W) begin
              w_state_next    = CAPTURE;
              w_locked_next   = 1'b1;
              w_good_cnt_next = 8'd0;
            end else begin
              w_good_cnt_next = r_good_cnt + 8'd1;
            end
          end else begin
            w_good_cnt_next = 8'd0;
          end
        end
        CAPTURE: begin
          if (w_frame_good) begin
            w_frame_done_next = 1'b1;
          end else begin
            w_state_next    = ALIGN;
            w_locked_next   = 1'b0;
            w_err_set       = 1'b1;
            w_good_cnt_next = 8'd0;
          end
        end
        default: begin
          w_state_next    = SEARCH;
          w_locked_next   = 1'b0;
          w_good_cnt_next = 8'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clock_50 or negedge reset) begin
    if (!reset) begin
      r_wr_adr     <= 16'd0;
      r_wr_data    <= 24'd0;
      r_wr_en      <= 1'b0;
      r_locked     <= 1'b0;
      r_frame_done <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_wr_en      <= w_wr_ok;
      r_locked     <= w_locked_next;
      r_frame_done <= w_frame_done_next;
      r_err        <= r_err | w_err_set;
      if (w_wr_ok) begin
        r_wr_adr  <= r_ptr[15:0];
        r_wr_data <= {vga_r, vga_g, vga_b};
      end
    end
  end

  assign wr_adr     = r_wr_adr;
  assign wr_data    = r_wr_data;
  assign wr_en      = r_wr_en;
  assign locked     = r_locked;
  assign frame_done = r_frame_done;
  assign err        = r_err;

endmodule
